div_tick_ctrl: RTL

Programmable, software-controlled tick scheduler that replaces free-running fixed clock division.
- Generates single-cycle enable pulses (tick_o) and a 50%-duty square wave (toggle_o) in the clk_i domain, with no derived clocks.
- Configured through a small 4-register write/read port driven by the CPU bus bridge.
- Supports stopped, periodic and one-shot operation with a sticky completion flag and interrupt.
- Consumers are display-scan, LED-blink and timer logic.

---
 rtl/div_tick_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/div_tick_ctrl.sv
// rtl/div_tick_ctrl.sv - programmable tick/toggle scheduler with 4-register config port
module div_tick_ctrl #(
    parameter int CNT_W   = 17,
    parameter int DEF_DIV = 9999
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_we_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    output logic        tick_o,
    output logic        toggle_o,
    output logic        busy_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEF_DIV_L = CNT_W'(DEF_DIV);

    state_t           state_q, state_d;
    logic             en_q, en_d;
    logic             mode_q, mode_d;
    logic             irq_en_q, irq_en_d;
    logic [CNT_W-1:0] div_sh_q, div_sh_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             tick_q, tick_d;
    logic             toggle_q, toggle_d;
    logic             irq_q, irq_d;
    logic [31:0]      rdata_q, rdata_d;

    logic wr_ctrl, wr_div, wr_stat, dis_wr;

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        mode_d    = mode_q;
        irq_en_d  = irq_en_q;
        div_sh_d  = div_sh_q;
        div_act_d = div_act_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        tick_d    = 1'b0;
        toggle_d  = toggle_q;
        rdata_d   = 32'd0;

        wr_ctrl = cfg_we_i && (cfg_addr_i == 2'd0);
        wr_div  = cfg_we_i && (cfg_addr_i == 2'd1);
        wr_stat = cfg_we_i && (cfg_addr_i == 2'd2);
        // A CTRL write clearing en acts in the same cycle it is presented
        dis_wr  = wr_ctrl && !cfg_wdata_i[0];

        if (wr_ctrl) begin
            en_d     = cfg_wdata_i[0];
            mode_d   = cfg_wdata_i[1];
            irq_en_d = cfg_wdata_i[2];
        end
        if (wr_div) begin
            div_sh_d = cfg_wdata_i[CNT_W-1:0];
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (en_q && !dis_wr) begin
                    state_d   = S_RUN;
                    div_act_d = div_sh_q;
                end
            end
            S_RUN: begin
                if (dis_wr) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    toggle_d = 1'b0;
                end else if (cnt_q == div_act_q) begin
                    tick_d    = 1'b1;
                    cnt_d     = '0;
                    toggle_d  = ~toggle_q;
                    div_act_d = div_sh_q;
                    if (mode_q) begin
                        state_d = S_DONE;
                        en_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Completion beats a simultaneous write-1-to-clear
        if (wr_stat && cfg_wdata_i[1]) begin
            done_d = 1'b0;
        end
        if (state_q == S_DONE) begin
            done_d = 1'b1;
        end
        irq_d = done_d & irq_en_d;

        case (cfg_addr_i)
            2'd0: rdata_d = {29'd0, irq_en_q, mode_q, en_q};
            2'd1: rdata_d = 32'(div_sh_q);
            2'd2: rdata_d = {30'd0, done_q, (state_q == S_RUN)};
            2'd3: rdata_d = 32'(cnt_q);
            default: rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            mode_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            div_sh_q  <= DEF_DIV_L;
            div_act_q <= DEF_DIV_L;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            tick_q    <= 1'b0;
            toggle_q  <= 1'b0;
            irq_q     <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            irq_en_q  <= irq_en_d;
            div_sh_q  <= div_sh_d;
            div_act_q <= div_act_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            tick_q    <= tick_d;
            toggle_q  <= toggle_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
        end
    end

    assign cfg_rdata_o = rdata_q;
    assign tick_o      = tick_q;
    assign toggle_o    = toggle_q;
    assign busy_o      = (state_q == S_RUN);
    assign irq_o       = irq_q;

endmodule
